// File: rtl/btb_pkg.sv
// Shared types and counter helpers for the fetch-side branch target buffer.
// The entry view is sized for the widest supported PC; narrower tables zero-extend into it.
package btb_pkg;

  localparam int BTB_MAX_AW = 64;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [BTB_MAX_AW-1:0] tag;
    logic [BTB_MAX_AW-1:0] target;
    logic [1:0]            ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_ctr_step(input logic [1:0] ctr, input logic inc);
    if (inc) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else     return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state of a 2-bit direction counter for one resolved branch/jump.
// Allocation seeds the counter; jumps force strongly-taken.
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       is_jump,
  input  logic       alloc,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (alloc)        ctr_nxt = is_jump ? CTR_ST : CTR_WT;
    else if (is_jump) ctr_nxt = CTR_ST;
    else              ctr_nxt = sat_ctr_step(ctr, taken);
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped, tagged branch target buffer with 2-bit counters.
// Fetch looks up with one cycle of latency; execute updates in a single edge.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  lkp_valid,
  input  logic                  lkp_stall,
  input  logic [ADDR_WIDTH-1:0] lkp_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_is_jump,
  input  logic [ADDR_WIDTH-1:0] upd_target
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_W    = ADDR_WIDTH - IDX_BITS - 2;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  // ---- stage p0: table read for lookup ----
  logic [IDX_BITS-1:0]   lkp_idx_p0;
  logic [TAG_W-1:0]      lkp_tag_p0;
  btb_entry_t            rd_p0;
  logic                  hit_p0;
  logic                  taken_p0;
  logic [ADDR_WIDTH-1:0] target_p0;

  assign lkp_idx_p0 = lkp_pc[IDX_BITS+1:2];
  assign lkp_tag_p0 = lkp_pc[ADDR_WIDTH-1:IDX_BITS+2];

  always_comb begin
    rd_p0        = '0;
    rd_p0.valid  = valid_q[lkp_idx_p0];
    rd_p0.tag    = BTB_MAX_AW'(tag_q[lkp_idx_p0]);
    rd_p0.target = BTB_MAX_AW'(target_q[lkp_idx_p0]);
    rd_p0.ctr    = ctr_q[lkp_idx_p0];
  end

  // A flush in the same edge wins over whatever the table still holds.
  assign hit_p0    = lkp_valid && !flush && rd_p0.valid &&
                     (rd_p0.tag == BTB_MAX_AW'(lkp_tag_p0));
  assign taken_p0  = hit_p0 && (rd_p0.ctr >= CTR_WT);
  assign target_p0 = taken_p0 ? rd_p0.target[ADDR_WIDTH-1:0] : lkp_pc + ADDR_WIDTH'(4);

  // ---- stage p1: registered prediction ----
  logic                  vld_p1;
  logic                  hit_p1;
  logic                  taken_p1;
  logic [ADDR_WIDTH-1:0] target_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      hit_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
    end else if (!lkp_stall) begin
      vld_p1    <= lkp_valid;
      hit_p1    <= hit_p0;
      taken_p1  <= taken_p0;
      target_p1 <= target_p0;
    end
  end

  assign pred_valid  = vld_p1;
  assign pred_hit    = hit_p1;
  assign pred_taken  = taken_p1;
  assign pred_target = target_p1;

  // ---- update path: resolve hit/alloc and write on the same edge ----
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic                upd_dir;
  logic                upd_en;
  logic                upd_alloc;
  logic                ctr_wr;
  logic                tgt_wr;
  logic                tag_wr;
  logic [1:0]          upd_ctr_cur;
  logic [1:0]          upd_ctr_nxt;
  logic                unused_upd_bits;

  assign upd_idx         = upd_pc[IDX_BITS+1:2];
  assign upd_tag         = upd_pc[ADDR_WIDTH-1:IDX_BITS+2];
  assign unused_upd_bits = &{1'b0, upd_pc[1:0]};
  assign upd_hit         = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // Jumps are unconditionally taken regardless of the reported direction.
  assign upd_dir         = upd_taken | upd_is_jump;
  assign upd_en          = upd_valid && !flush;
  assign upd_alloc       = !upd_hit && upd_dir;
  assign ctr_wr          = upd_en && (upd_hit || upd_dir);
  assign tgt_wr          = upd_en && upd_dir;
  assign tag_wr          = upd_en && upd_alloc;
  assign upd_ctr_cur     = ctr_q[upd_idx];

  btb_sat_counter u_sat_counter (
    .ctr     (upd_ctr_cur),
    .taken   (upd_dir),
    .is_jump (upd_is_jump),
    .alloc   (upd_alloc),
    .ctr_nxt (upd_ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_SNT;
    end else begin
      if (flush)       valid_q          <= '0;
      else if (tag_wr) valid_q[upd_idx] <= 1'b1;
      if (ctr_wr) ctr_q[upd_idx] <= upd_ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_wr) tag_q[upd_idx]    <= upd_tag;
    if (tgt_wr) target_q[upd_idx] <= upd_target;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: lookups push expected predictions,
// which are popped and compared once the registered outputs appear.
module tb_btb_predictor;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          lkp_valid;
  logic          lkp_stall;
  logic [AW-1:0] lkp_pc;
  logic          pred_valid;
  logic          pred_hit;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic          upd_taken;
  logic          upd_is_jump;
  logic [AW-1:0] upd_target;

  typedef struct {
    logic          hit;
    logic          taken;
    logic [AW-1:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  btb_predictor #(.ADDR_WIDTH(AW), .ENTRIES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .lkp_valid   (lkp_valid),
    .lkp_stall   (lkp_stall),
    .lkp_pc      (lkp_pc),
    .pred_valid  (pred_valid),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_is_jump (upd_is_jump),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic lkp(input logic [AW-1:0] pc, input logic h, input logic t, input logic [AW-1:0] tgt);
    exp_t e;
    lkp_valid = 1'b1;
    lkp_pc    = pc;
    e.hit     = h;
    e.taken   = t;
    e.tgt     = tgt;
    exp_q.push_back(e);
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic tk, input logic jmp, input logic [AW-1:0] tgt);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_is_jump = jmp;
    upd_target  = tgt;
  endtask

  // One clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    logic was_lkp;
    logic was_stall;
    exp_t e;
    was_lkp   = lkp_valid && !lkp_stall;
    was_stall = lkp_stall;
    @(posedge clk);
    @(negedge clk);
    if (was_lkp) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pred_valid",  {63'd0, pred_valid}, 64'd1);
        check("pred_hit",    {63'd0, pred_hit},   {63'd0, e.hit});
        check("pred_taken",  {63'd0, pred_taken}, {63'd0, e.taken});
        check("pred_target", pred_target, e.tgt);
      end
    end else if (!was_stall) begin
      check("idle_valid", {63'd0, pred_valid}, 64'd0);
    end
    lkp_valid   = 1'b0;
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_is_jump = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; lkp_valid = 1'b0; lkp_stall = 1'b0; lkp_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_is_jump = 1'b0; upd_target = '0;
    repeat (2) @(negedge clk);
    check("rst_valid",  {63'd0, pred_valid}, 64'd0);
    check("rst_hit",    {63'd0, pred_hit},   64'd0);
    check("rst_taken",  {63'd0, pred_taken}, 64'd0);
    check("rst_target", pred_target, 64'd0);
    rst = 1'b0;
    tick();

    // Empty table: miss, fall-through PC+4 (including wrap at top of space)
    lkp(64'h1000, 0, 0, 64'h1004); tick();
    lkp(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0); tick();

    // Allocation by a taken branch seeds a weakly-taken counter
    upd(64'h1000, 1, 0, 64'h0F00); tick();
    lkp(64'h1000, 1, 1, 64'h0F00); tick();

    // Hysteresis down to 00 (entry stays valid) and back up
    upd(64'h1000, 0, 0, 64'hDEAD); tick();
    upd(64'h1000, 0, 0, 64'hDEAD); tick();
    lkp(64'h1000, 1, 0, 64'h1004); tick();
    upd(64'h1000, 1, 0, 64'h0F00); tick();
    lkp(64'h1000, 1, 0, 64'h1004); tick();
    upd(64'h1000, 1, 0, 64'h0F00); tick();
    lkp(64'h1000, 1, 1, 64'h0F00); tick();
    // Saturation at 11: one not-taken after overflow attempts still predicts taken
    upd(64'h1000, 1, 0, 64'h0F00); tick();
    upd(64'h1000, 1, 0, 64'h0F00); tick();
    upd(64'h1000, 0, 0, 64'hBEEF); tick();
    lkp(64'h1000, 1, 1, 64'h0F00); tick();

    // Aliasing on index 0 with a different tag
    lkp(64'h1040, 0, 0, 64'h1044); tick();
    upd(64'h1040, 1, 0, 64'h5000); tick();
    lkp(64'h1000, 0, 0, 64'h1004); tick();
    lkp(64'h1040, 1, 1, 64'h5000); tick();
    // Jump on a weakened hit forces strongly-taken and new target
    upd(64'h1040, 0, 0, 64'h7777); tick();
    upd(64'h1040, 1, 1, 64'h6000); tick();
    lkp(64'h1040, 1, 1, 64'h6000); tick();

    // Same-edge lookup and update read the old contents
    pulse_rst();
    lkp(64'h2000, 0, 0, 64'h2004);
    upd(64'h2000, 1, 1, 64'h3000); tick();
    lkp(64'h2000, 1, 1, 64'h3000); tick();

    // Fill four entries, then flush with a same-edge update and lookup
    for (int i = 0; i < 4; i++) begin
      upd(64'h100 + 64'(4 * i), 1, 0, 64'hA00 + 64'(16 * i)); tick();
    end
    for (int i = 0; i < 4; i++) begin
      lkp(64'h100 + 64'(4 * i), 1, 1, 64'hA00 + 64'(16 * i)); tick();
    end
    flush = 1'b1;
    upd(64'h110, 1, 0, 64'hB00);
    lkp(64'h100, 0, 0, 64'h104); tick();
    for (int i = 0; i < 4; i++) begin
      lkp(64'h100 + 64'(4 * i), 0, 0, 64'h104 + 64'(4 * i)); tick();
    end
    lkp(64'h110, 0, 0, 64'h114); tick();

    // Stall holds a hit prediction while lookup inputs change
    upd(64'h100, 1, 0, 64'hC00); tick();
    lkp(64'h100, 1, 1, 64'hC00); tick();
    lkp_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lkp_valid = (i != 1);
      lkp_pc    = 64'h999 + 64'(i);
      tick();
      check("stall_valid",  {63'd0, pred_valid}, 64'd1);
      check("stall_hit",    {63'd0, pred_hit},   64'd1);
      check("stall_taken",  {63'd0, pred_taken}, 64'd1);
      check("stall_target", pred_target, 64'hC00);
    end

    // Asynchronous reset mid-stall clears outputs before any clock edge
    rst = 1'b1;
    #1;
    check("arst_valid",  {63'd0, pred_valid}, 64'd0);
    check("arst_hit",    {63'd0, pred_hit},   64'd0);
    check("arst_taken",  {63'd0, pred_taken}, 64'd0);
    check("arst_target", pred_target, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    lkp_stall = 1'b0;
    lkp_valid = 1'b0;
    tick();
    lkp(64'h100, 0, 0, 64'h104); tick();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
